// File: rtl/npu_lsu_resp.sv
// Responder end of one LSU request/response channel: runs each request against a local
// single-port synchronous SRAM and returns one in-order response per request.
module npu_lsu_resp #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 4096,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         srst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_we_i,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [DATA_W-1:0]            req_wdata_i,
    input  logic [DATA_W/8-1:0]          req_be_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [DATA_W-1:0]            rsp_rdata_o,
    output logic                         rsp_we_o,
    output logic                         rsp_err_o,
    output logic                         busy_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    output logic [DATA_W/8-1:0]          mem_be_o,
    input  logic [DATA_W-1:0]            mem_rdata_i
);

    localparam int MA_W  = $clog2(MEM_WORDS);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W:0]    ADDR_LIM = (ADDR_W + 1)'(MEM_WORDS);
    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(RSP_DEPTH - 1);

    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              pipe_vld_q, pipe_vld_d;
    logic              pipe_we_q, pipe_we_d;
    logic              pipe_err_q, pipe_err_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0] fifo_rdata_q [RSP_DEPTH];
    logic [DATA_W-1:0] fifo_rdata_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_we_q, fifo_we_d;
    logic [RSP_DEPTH-1:0] fifo_err_q, fifo_err_d;

    logic in_range, accept, rsp_vld, rsp_hs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    assign in_range = ({1'b0, req_addr_i} < ADDR_LIM);
    assign accept   = req_valid_i & rdy_q & ~srst_i;
    assign rsp_vld  = (fifo_cnt_q != '0);
    assign rsp_hs   = rsp_vld & rsp_ready_i;

    // SRAM strobe goes out in the accept cycle; out-of-range requests never touch the array.
    assign mem_en_o    = accept & in_range;
    assign mem_we_o    = req_we_i;
    assign mem_addr_o  = req_addr_i[MA_W-1:0];
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_be_i;

    assign req_ready_o = rdy_q;
    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_vld;
    assign rsp_rdata_o = rsp_vld ? fifo_rdata_q[rd_ptr_q] : '0;
    assign rsp_we_o    = rsp_vld & fifo_we_q[rd_ptr_q];
    assign rsp_err_o   = rsp_vld & fifo_err_q[rd_ptr_q];

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({accept, rsp_hs})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
        rdy_d  = (out_cnt_d < DEPTH_C);
        busy_d = (out_cnt_d != '0);

        pipe_vld_d = accept;
        pipe_we_d  = req_we_i;
        pipe_err_d = ~in_range;

        fifo_rdata_d = fifo_rdata_q;
        fifo_we_d    = fifo_we_q;
        fifo_err_d   = fifo_err_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        // Outstanding limit guarantees the FIFO has room for every pipe push.
        if (pipe_vld_q) begin
            fifo_rdata_d[wr_ptr_q] = (!pipe_we_q && !pipe_err_q) ? mem_rdata_i : '0;
            fifo_we_d[wr_ptr_q]    = pipe_we_q;
            fifo_err_d[wr_ptr_q]   = pipe_err_q;
            wr_ptr_d               = ptr_inc(wr_ptr_q);
        end
        if (rsp_hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({pipe_vld_q, rsp_hs})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            out_cnt_q  <= '0;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            pipe_vld_q <= 1'b0;
            pipe_we_q  <= 1'b0;
            pipe_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_we_q  <= pipe_we_d;
            pipe_err_q <= pipe_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_rdata_q <= fifo_rdata_d;
        fifo_we_q    <= fifo_we_d;
        fifo_err_q   <= fifo_err_d;
    end

endmodule

// File: tb/tb_npu_lsu_resp.sv
// Bench for npu_lsu_resp: directed and random traffic against a queue-based response model
// and an array model of the scratchpad contents.
module tb_npu_lsu_resp;
    localparam int ADDR_W = 16, DATA_W = 32, MEM_WORDS = 4096, DEPTH = 4, MA_W = 12;

    logic              clk = 1'b0;
    logic              srst_i;
    logic              req_valid_i, req_ready_o, req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic [3:0]        req_be_i;
    logic              rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o, busy_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              mem_en_o, mem_we_o;
    logic [MA_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;

    npu_lsu_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .RSP_DEPTH(DEPTH)) dut (
        .clk_i(clk), .srst_i(srst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    bit [31:0] sram [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    typedef struct { logic [31:0] rdata; logic we; logic err; int acc; } rsp_t;
    rsp_t      q[$];
    bit [31:0] ref_mem [MEM_WORDS];
    int        total = 0, bad = 0, cyc = 0;
    bit        last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, update the model, advance.
    task automatic tick();
        bit exp_rdy, exp_vld, in_rng, acc;
        rsp_t r;
        @(negedge clk);
        last_acc = 0;
        if (srst_i) begin
            check("mem_en_in_reset", mem_en_o, 0);
            q.delete();
        end else begin
            exp_rdy = (q.size() < DEPTH);
            exp_vld = (q.size() > 0) && (q[0].acc + 2 <= cyc);
            in_rng  = (int'(req_addr_i) < MEM_WORDS);
            acc     = req_valid_i && exp_rdy;
            check("req_ready", req_ready_o, exp_rdy);
            check("busy", busy_o, q.size() != 0);
            check("rsp_valid", rsp_valid_o, exp_vld);
            check("mem_en", mem_en_o, acc && in_rng);
            if (exp_vld) begin
                check("rsp_rdata", rsp_rdata_o, q[0].rdata);
                check("rsp_we", rsp_we_o, q[0].we);
                check("rsp_err", rsp_err_o, q[0].err);
                if (rsp_ready_i) void'(q.pop_front());
            end
            if (acc) begin
                r.we  = req_we_i;
                r.err = !in_rng;
                r.acc = cyc;
                r.rdata = (!req_we_i && in_rng) ? ref_mem[req_addr_i[MA_W-1:0]] : 32'h0;
                if (req_we_i && in_rng)
                    for (int b = 0; b < 4; b++)
                        if (req_be_i[b]) ref_mem[req_addr_i[MA_W-1:0]][8*b +: 8] = req_wdata_i[8*b +: 8];
                q.push_back(r);
                last_acc = 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input bit we, input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int n = 0;
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_be_i = be;
        do begin tick(); n++; end while (!last_acc && n < 50);
        if (!last_acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        req_valid_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        req_valid_i = 0; rsp_ready_i = 1;
        while (q.size() > 0 && n < 200) begin tick(); n++; end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int dut_acc;
        srst_i = 1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0; req_be_i = 0;
        rsp_ready_i = 0;
        tick(); tick();
        srst_i = 0;
        tick();
        check("reset_rdata", rsp_rdata_o, 0);
        check("reset_we", rsp_we_o, 0);
        check("reset_err", rsp_err_o, 0);

        // write then read back, minimum latency
        rsp_ready_i = 1;
        send(1, 16'h0010, 32'hDEADBEEF, 4'hF);
        send(0, 16'h0010, 0, 0);
        idle();
        drain();

        // backpressure fills outstanding limit
        rsp_ready_i = 0;
        dut_acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1; req_we_i = 0; req_addr_i = 16'(i);
            #2;
            if (req_ready_o) dut_acc++;
            tick();
        end
        idle();
        tick();
        check("full_accepts", dut_acc, 4);
        check("full_ready", req_ready_o, 0);
        check("full_busy", busy_o, 1);
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        tick();
        check("ready_after_hs", req_ready_o, 1);
        drain();

        // out-of-range between neighbouring reads
        send(0, 16'h0010, 0, 0);
        send(0, 16'h1000, 0, 0);
        send(0, 16'hFFFF, 0, 0);
        send(0, 16'h0010, 0, 0);
        idle();
        drain();

        // partial and empty byte enables
        send(1, 16'h0020, 32'h11223344, 4'hF);
        send(1, 16'h0020, 32'h0000ABCD, 4'h3);
        send(0, 16'h0020, 0, 0);
        send(1, 16'h0020, 32'hFFFFFFFF, 4'h0);
        send(0, 16'h0020, 0, 0);
        idle();
        drain();

        // fill 0..99, then stream 100 reads back to back
        for (int i = 0; i < 100; i++) send(1, 16'(i), $urandom, 4'hF);
        idle();
        drain();
        for (int i = 0; i < 100; i++) send(0, 16'(i), 0, 0);
        idle();
        drain();

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_we_i    = $urandom_range(0, 1);
            req_addr_i  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(4096, 65535))
                                                       : 16'($urandom_range(0, 127));
            req_wdata_i = $urandom;
            req_be_i    = 4'($urandom_range(0, 15));
            rsp_ready_i = $urandom_range(0, 1);
            tick();
        end
        drain();

        // reset with requests in flight
        rsp_ready_i = 0;
        send(0, 16'h0001, 0, 0);
        send(1, 16'h0002, 32'h12345678, 4'hF);
        send(0, 16'h0003, 0, 0);
        idle();
        tick(); tick();
        srst_i = 1;
        tick();
        srst_i = 0;
        tick();
        check("post_rst_valid", rsp_valid_o, 0);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_ready", req_ready_o, 1);
        rsp_ready_i = 1;
        for (int i = 0; i < 6; i++) tick();
        send(0, 16'h0002, 0, 0);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/npu_lsu_resp.md
Name: npu_lsu_resp

Overview:
- Responder (slave) end of one ADDRDATA bus channel. The compute unit drives that channel as master.
- Accepts read and write requests, executes them on a local single-port synchronous scratchpad SRAM, and returns one in-order response per request.
- A bounded response FIFO absorbs master backpressure. One instance sits behind each of the LSU 0/1/2 master channels.

Parameters:
- ADDR_W, 16, word-address width of the request.
- DATA_W, 32, data word width. Must be a multiple of 8.
- MEM_WORDS, 4096, number of SRAM words. Must be ≤ 2^ADDR_W.
- RSP_DEPTH, 4, maximum outstanding requests and response FIFO depth. Must be ≥ 3 for full throughput.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  word address.
- req_wdata_i  in  DATA_W  write data.
- req_be_i  in  DATA_W/8  byte enables (writes only).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  master accepts the response.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_we_o  out  1  echo of req_we for this response.
- rsp_err_o  out  1  address out of range.
- busy_o  out  1  outstanding count ≠ 0.
- mem_en_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write.
- mem_addr_o  out  $clog2(MEM_WORDS)  SRAM address.
- mem_wdata_o  out  DATA_W  SRAM write data.
- mem_be_o  out  DATA_W/8  SRAM byte enables.
- mem_rdata_i  in  DATA_W  SRAM read data, valid 1 cycle after a read strobe.

Behaviour:
- Reset is synchronous and active high; clk_i is the only clock. On srst_i:
  - outstanding count = 0, pipe stage empty, FIFO empty.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_we_o = 0, rsp_err_o = 0, busy_o = 0.
  - req_ready_o = 1 from the first cycle after reset.
  - mem_en_o = 0 while srst_i is asserted.
- Reset mid-operation discards all in-flight requests and responses. No response is emitted for them.
- req_ready_o = (outstanding < RSP_DEPTH).
  - Driven from registered state only. There is no combinational path from rsp_ready_i or req_valid_i to req_ready_o.
- Accept in cycle N (req_valid_i & req_ready_o):
  - In-range address (addr < MEM_WORDS): in the same cycle, mem_en_o = 1 and mem_we_o/addr/wdata/be are driven combinationally from the request.
  - Out-of-range address: mem_en_o = 0, and the request is tagged err.
  - In both cases the request enters a 1-entry pipe stage holding {we, err}.
- Cycle N+1: the pipe stage pushes {rdata = (read & !err) ? mem_rdata_i : 0, we, err} into the response FIFO.
- Cycle N+2: the response is visible on rsp_* at the earliest. Minimum latency is 2 cycles; throughput is 1 request/cycle when rsp_ready_i is held high.
- Responses are strictly in request order. rsp_* is the FIFO head and stays stable while rsp_valid_o & !rsp_ready_i.
- Outstanding count:
  - +1 on request accept, −1 on response handshake.
  - A simultaneous accept and handshake leaves it unchanged.
  - It never exceeds RSP_DEPTH, so the FIFO can never overflow and no push is ever dropped.
- Full: at outstanding = RSP_DEPTH, req_ready_o = 0. A handshake in cycle M raises req_ready_o in M+1.
- Empty: rsp_valid_o = 0. rsp_ready_i with no valid response has no effect.
- Write then read to the same address (back-to-back) returns the new data: the SRAM write completes at the edge closing cycle N.
- Byte enables: only bytes with be = 1 are written. be = 0 produces a normal write response with no SRAM change.
- Wrap-around: FIFO read/write pointers wrap modulo RSP_DEPTH. There is no address wrap; out-of-range is an error, never aliased.
- busy_o = (outstanding ≠ 0), registered.

Test Plan:
- Reset, then write addr 0x0010 = 0xDEADBEEF with be = 0xF, then read 0x0010 → responses {we=1, err=0, rdata=0} then {we=0, err=0, rdata=0xDEADBEEF}; read response at accept + 2.
- With rsp_ready_i held low, issue 6 reads at RSP_DEPTH = 4 → exactly 4 accepted, req_ready_o = 0 and busy_o = 1; after one response handshake, req_ready_o = 1 the next cycle.
- Read addr 0x1000 (= MEM_WORDS) → mem_en_o stays 0; response rsp_err_o = 1, rdata = 0, ordered between neighbouring valid reads.
- Partial write be = 0x3, data 0x0000ABCD over 0x11223344 → read back 0x1122ABCD.
- Streaming: 100 back-to-back reads of addresses 0..99 with rsp_ready_i = 1 → 100 in-order responses, one per cycle, with no bubble after the first (first at accept + 2); then rsp_ready_i toggles randomly → order and data are unchanged.
- Assert srst_i with 3 requests outstanding → next cycle rsp_valid_o = 0, busy_o = 0, req_ready_o = 1; no stale response appears afterwards.
